uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 32 +++
 rtl/rr_picker.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types, constants and the round-robin search used by the UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    IDLE,
    XFER
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First asserted request at or above ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !res.found && req[3'(idx)]) begin
        res.found = 1'b1;
        res.idx   = 3'(idx);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first asserted request searching upward from a pointer.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);

  logic [MAX_REQ-1:0] w_req;
  logic [2:0]         w_ptr;
  rr_pick_t           w_pick;

  assign w_req   = MAX_REQ'(i_req);
  assign w_ptr   = 3'(i_ptr);
  assign w_pick  = rr_pick(w_req, w_ptr, NUM_REQ);
  assign o_idx   = $clog2(NUM_REQ)'(w_pick.idx);
  assign o_valid = w_pick.found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX serializer between NUM_REQ sources.
// Define UART_TX_ARBITER_PRIORITY_EN to give requester 0 absolute priority in arbitration.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_tx_valid,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_busy
);

  localparam int unsigned IdxW      = $clog2(NUM_REQ);
  localparam logic [7:0]  BurstLast = 8'(MAX_BURST - 1);

  state_e          r_state, w_state_d;
  logic [IdxW-1:0] r_rr_ptr, w_rr_ptr_d;
  logic [IdxW-1:0] r_grant_id, w_grant_id_d;
  logic [7:0]      r_beat_cnt, w_beat_cnt_d;

  logic [NUM_REQ-1:0]    w_pick_req;
  logic [IdxW-1:0]       w_pick_idx;
  logic                  w_pick_valid;
  logic [IdxW-1:0]       w_sel_idx;
  logic                  w_sel_valid;
  logic                  w_adv_ptr;
  logic [IdxW-1:0]       w_next_ptr;
  logic                  w_g_valid;
  logic                  w_g_last;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic                  w_beat;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_picker (
    .i_req  (w_pick_req),
    .i_ptr  (r_rr_ptr),
    .o_idx  (w_pick_idx),
    .o_valid(w_pick_valid)
  );

`ifdef UART_TX_ARBITER_PRIORITY_EN
  // Requester 0 bypasses the rotation; the picker only rotates over 1..NUM_REQ-1.
  assign w_pick_req  = {i_req_valid[NUM_REQ-1:1], 1'b0};
  assign w_sel_idx   = i_req_valid[0] ? '0 : w_pick_idx;
  assign w_sel_valid = i_req_valid[0] | w_pick_valid;
  assign w_adv_ptr   = (r_grant_id != '0);
`else
  assign w_pick_req  = i_req_valid;
  assign w_sel_idx   = w_pick_idx;
  assign w_sel_valid = w_pick_valid;
  assign w_adv_ptr   = 1'b1;
`endif

  assign w_next_ptr = (32'(r_grant_id) == NUM_REQ - 1) ? '0 : r_grant_id + 1'b1;
  assign w_g_valid  = i_req_valid[r_grant_id];
  assign w_g_last   = i_req_last[r_grant_id];
  assign w_g_data   = i_req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_grant_id <= w_grant_id_d;
      r_beat_cnt <= w_beat_cnt_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_rr_ptr_d   = r_rr_ptr;
    w_grant_id_d = r_grant_id;
    w_beat_cnt_d = r_beat_cnt;
    w_beat       = 1'b0;
    o_tx_valid   = 1'b0;
    o_tx_data    = '0;
    o_req_ready  = '0;
    unique case (r_state)
      IDLE: begin
        w_beat_cnt_d = '0;
        if (w_sel_valid) begin
          w_grant_id_d = w_sel_idx;
          w_state_d    = XFER;
        end
      end
      XFER: begin
        o_tx_valid              = w_g_valid;
        o_tx_data               = w_g_data;
        o_req_ready[r_grant_id] = i_tx_ready;
        w_beat                  = w_g_valid & i_tx_ready;
        if (w_beat) begin
          w_beat_cnt_d = r_beat_cnt + 8'd1;
          // Release on end of message or once the burst budget is spent.
          if (w_g_last || r_beat_cnt == BurstLast) begin
            w_state_d    = IDLE;
            w_beat_cnt_d = '0;
            if (w_adv_ptr) w_rr_ptr_d = w_next_ptr;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign o_grant_id = r_grant_id;
  assign o_busy     = (r_state == XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a queue-based message-level reference model.
module tb_uart_tx_arbiter;

  localparam int unsigned NReq     = 4;
  localparam int unsigned Dw       = 8;
  localparam int unsigned MaxBurst = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NReq-1:0]   req_valid, req_last, req_ready;
  logic [NReq*Dw-1:0] req_data;
  logic              tx_valid, tx_ready, busy;
  logic [Dw-1:0]     tx_data;
  logic [1:0]        grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (NReq),
    .DATA_WIDTH(Dw),
    .MAX_BURST (MaxBurst)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_req_valid(req_valid),
    .i_req_data (req_data),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .o_grant_id (grant_id),
    .o_busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Source-side message queues, expected per-source streams, observed serializer streams.
  logic [Dw-1:0] src_q[NReq][$];
  bit            src_l[NReq][$];
  logic [Dw-1:0] exp_s[NReq][$];
  logic [Dw-1:0] obs_s[NReq][$];
  bit            drv_v[NReq];
  int            glog[$];
  bit            prev_busy = 1'b0;

  // Reference model: current grant (-1 = none), visible grant id, pointer, beats in grant.
  int m_g = -1, m_gid = 0, m_rr = 0, m_cnt = 0;

  function automatic int rr_winner(input logic [NReq-1:0] v, input int ptr);
`ifdef UART_TX_ARBITER_PRIORITY_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 0; k < NReq; k++) if (v[(ptr + k) % NReq]) return (ptr + k) % NReq;
    return -1;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NReq; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic push_byte(input int i, input logic [Dw-1:0] b, input bit last, input bit track);
    src_q[i].push_back(b);
    src_l[i].push_back(last);
    if (track) exp_s[i].push_back(b);
  endtask

  task automatic push_msg(input int i, input int len);
    for (int k = 0; k < len; k++) push_byte(i, Dw'($urandom), k == len - 1, 1'b1);
  endtask

  task automatic cycle(input bit do_rst, input int p_up, input int p_rdy);
    logic [NReq-1:0] exp_rdy;
    bit              beat, last;
    @(negedge clk);
    rst      = do_rst;
    tx_ready = ($urandom_range(99) < p_rdy);
    for (int i = 0; i < NReq; i++) begin
      if (src_q[i].size() == 0) drv_v[i] = 1'b0;
      else if (!drv_v[i]) drv_v[i] = ($urandom_range(99) < p_up);
      req_valid[i]         = drv_v[i];
      req_data[i*Dw +: Dw] = (src_q[i].size() != 0) ? src_q[i][0] : Dw'($urandom);
      req_last[i]          = (src_q[i].size() != 0) ? src_l[i][0] : 1'($urandom);
    end
    #1;
    exp_rdy = '0;
    if (m_g >= 0) exp_rdy[m_g] = tx_ready;
    check_eq("busy", busy, m_g >= 0);
    check_eq("grant_id", grant_id, m_gid);
    check_eq("tx_valid", tx_valid, (m_g >= 0) ? req_valid[m_g] : 1'b0);
    check_eq("tx_data", tx_data, (m_g >= 0) ? req_data[m_g*Dw +: Dw] : '0);
    check_eq("req_ready", req_ready, exp_rdy);
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;
    // Advance the model across the coming rising edge.
    if (do_rst) begin
      m_g = -1; m_gid = 0; m_rr = 0; m_cnt = 0;
    end else if (m_g < 0) begin
      m_g = rr_winner(req_valid, m_rr);
      if (m_g >= 0) begin
        m_gid = m_g;
        m_cnt = 0;
      end
    end else begin
      beat = req_valid[m_g] && tx_ready;
      if (beat) begin
        obs_s[m_g].push_back(tx_data);
        last = src_l[m_g].pop_front();
        void'(src_q[m_g].pop_front());
        drv_v[m_g] = 1'($urandom_range(1));
        m_cnt++;
        if (last || m_cnt == MaxBurst) begin
`ifdef UART_TX_ARBITER_PRIORITY_EN
          if (m_g != 0) m_rr = (m_g + 1) % NReq;
`else
          m_rr = (m_g + 1) % NReq;
`endif
          m_g   = -1;
          m_cnt = 0;
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int bound, input int p_up, input int p_rdy);
    for (int n = 0; n < bound && (pending() > 0 || m_g >= 0); n++) cycle(1'b0, p_up, p_rdy);
    check_eq({"drain_", tag}, pending(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    for (int i = 0; i < NReq; i++) drv_v[i] = 1'b0;
    cycle(1'b1, 0, 0);
    cycle(1'b1, 0, 0);
    cycle(1'b0, 0, 0);

    // Single source, three-byte message.
    glog.delete();
    push_byte(0, 8'h41, 1'b0, 1'b1);
    push_byte(0, 8'h42, 1'b0, 1'b1);
    push_byte(0, 8'h43, 1'b1, 1'b1);
    drain("single", 30, 100, 100);
    cycle(1'b0, 100, 100);
    check_eq("single_grants", glog.size(), 1);
    if (glog.size() > 0) check_eq("single_gid", glog[0], 0);

    // Burst limit: 20-byte message on 2, with 1 arriving after 2 is granted.
    glog.delete();
    push_msg(2, 20);
    cycle(1'b0, 100, 100);
    push_msg(1, 1);
    drain("burst", 200, 100, 100);
    check_eq("burst_grants", glog.size(), 3);
    for (int k = 0; k < glog.size() && k < 3; k++) check_eq("burst_order", glog[k], (k == 1) ? 1 : 2);

    // Reset during the second beat of a five-byte message.
    for (int k = 0; k < 5; k++) push_byte(1, Dw'(8'h60 + k), k == 4, 1'b0);
    for (int n = 0; n < 30 && obs_s[1].size() < exp_s[1].size() + 1; n++) cycle(1'b0, 100, 100);
    check_eq("rst_pre_beats", obs_s[1].size(), exp_s[1].size() + 1);
    if (obs_s[1].size() > 0) check_eq("rst_pre_byte", obs_s[1][obs_s[1].size()-1], 8'h60);
    cycle(1'b1, 100, 100);
    src_q[1].delete();
    src_l[1].delete();
    drv_v[1] = 1'b0;
    if (obs_s[1].size() > 0) void'(obs_s[1].pop_back());
    glog.delete();
    push_msg(3, 1);
    push_msg(0, 1);
    drain("post_rst", 40, 100, 100);
    cycle(1'b0, 100, 100);
    check_eq("post_rst_grants", glog.size(), 2);
    for (int k = 0; k < glog.size() && k < 2; k++) check_eq("post_rst_order", glog[k], (k == 0) ? 0 : 3);

    // Randomized contention, bubbles, backpressure and burst splits.
    for (int m = 0; m < 5; m++)
      for (int i = 0; i < NReq; i++) push_msg(i, int'($urandom_range(1, 24)));
    drain("random", 6000, 60, 70);

    for (int i = 0; i < NReq; i++) begin
      check_eq("stream_len", obs_s[i].size(), exp_s[i].size());
      for (int k = 0; k < obs_s[i].size() && k < exp_s[i].size(); k++)
        if (obs_s[i][k] !== exp_s[i][k]) check_eq("stream_byte", obs_s[i][k], exp_s[i][k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
